// File: rtl/div_result_bcd.sv
// div_result_bcd
//
// Sequential binary-to-BCD converter that sits behind the combinational
// unsigned divider. It takes one quotient/remainder/error triple, converts
// quotient and remainder to packed BCD in parallel with shift-and-add-3
// (double dabble, one bit per clock), and holds the result for the readout
// stage.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps its payload stable from
// raising valid until that edge; ready carries no payload and may be high
// without valid (that is simply ignored).
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready = (state == IDLE) && !rst
//   D, R, err       quotient, remainder, divide-by-zero flag from divider
//   out_valid/ready output handshake
//   D_bcd, R_bcd    packed BCD quotient/remainder, digit 0 in bits [3:0]
//   err_out         captured err, held with the result
//   busy            high while the conversion is shifting
module div_result_bcd #(
  parameter int Width  = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Width-1:0]      D,
  input  logic [Width-1:0]      R,
  input  logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   D_bcd,
  output logic [4*DIGITS-1:0]   R_bcd,
  output logic                  err_out,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(Width + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(Width);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [Width-1:0]  d_sh_q, d_sh_d;
  logic [Width-1:0]  r_sh_q, r_sh_d;
  logic [BW-1:0]     d_acc_q, d_acc_d;
  logic [BW-1:0]     r_acc_q, r_acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              err_out_q, err_out_d;
  logic              busy_q, busy_d;
  logic [BW-1:0]     d_bcd_q, d_bcd_d;
  logic [BW-1:0]     r_bcd_q, r_bcd_d;

  // Correct every digit that would overflow past 9 after doubling. Digits
  // are independent: no carry propagates between them here.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign err_out   = err_out_q;
  assign busy      = busy_q;
  assign D_bcd     = d_bcd_q;
  assign R_bcd     = r_bcd_q;

  always_comb begin
    state_d     = state_q;
    d_sh_d      = d_sh_q;
    r_sh_d      = r_sh_q;
    d_acc_d     = d_acc_q;
    r_acc_d     = r_acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    err_out_d   = err_out_q;
    busy_d      = busy_q;
    d_bcd_d     = d_bcd_q;
    r_bcd_d     = r_bcd_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          d_sh_d    = D;
          r_sh_d    = R;
          d_acc_d   = '0;
          r_acc_d   = '0;
          cnt_d     = CNT_LOAD;
          err_out_d = err;
          if (err) begin
            // Error items skip conversion; out_valid follows one edge later
            // from the DONE state.
            state_d = DONE;
            d_bcd_d = '0;
            r_bcd_d = '0;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
      end

      SHIFT: begin
        // Operand MSB shifts into accumulator bit 0.
        {d_acc_d, d_sh_d} = {add3(d_acc_q), d_sh_q} << 1;
        {r_acc_d, r_sh_d} = {add3(r_acc_q), r_sh_q} << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d     = DONE;
          d_bcd_d     = d_acc_d;
          r_bcd_d     = r_acc_d;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      d_sh_q      <= '0;
      r_sh_q      <= '0;
      d_acc_q     <= '0;
      r_acc_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      err_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      d_bcd_q     <= '0;
      r_bcd_q     <= '0;
    end else begin
      state_q     <= state_d;
      d_sh_q      <= d_sh_d;
      r_sh_q      <= r_sh_d;
      d_acc_q     <= d_acc_d;
      r_acc_q     <= r_acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      err_out_q   <= err_out_d;
      busy_q      <= busy_d;
      d_bcd_q     <= d_bcd_d;
      r_bcd_q     <= r_bcd_d;
    end
  end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sequential binary-to-BCD converter directly downstream of the combinational unsigned divider.
- Accepts one quotient/remainder/error triple through a valid/ready handshake.
- Converts quotient and remainder in parallel to packed BCD using shift-and-add-3 (double dabble), one bit per clock.
- Presents the result to the display/readout stage through a second valid/ready handshake.

Parameters:
- Width, 4, bit width of quotient D and remainder R; must match the divider's Width.
- DIGITS, 2, number of BCD digits per operand; must satisfy 10^DIGITS > 2^Width-1 (Width=8 requires DIGITS=3).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  divider result is valid.
- in_ready  output  1  block can accept a result.
- D  input  Width  quotient from divider.
- R  input  Width  remainder from divider.
- err  input  1  divide-by-zero flag from divider.
- out_valid  output  1  BCD result is valid.
- out_ready  input  1  consumer accepts the result.
- D_bcd  output  4*DIGITS  packed BCD quotient; digit 0 in bits [3:0].
- R_bcd  output  4*DIGITS  packed BCD remainder.
- err_out  output  1  registered copy of captured err.
- busy  output  1  high in SHIFT state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset (rst high at an edge):
  - state <= IDLE.
  - out_valid, err_out, busy <= 0.
  - D_bcd, R_bcd <= 0.
  - Shift registers and bit counter cleared.
  - in_ready is 0 while rst is high.
  - Reset mid-operation aborts conversion silently; no out_valid is produced for the aborted item.
- Outputs are registered, except in_ready = (state==IDLE) && !rst.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_valid && in_ready at edge E0: capture D, R, err; clear both BCD accumulators; load counter = Width.
  - If err = 1: go directly to DONE; D_bcd = R_bcd = 0, err_out = 1.
  - Otherwise: go to SHIFT, busy = 1.
- SHIFT, one step per edge:
  - For each digit of each accumulator, add 3 if the digit is >= 5, using the value before the shift.
  - Then shift {accumulator, operand shift reg} left by 1; the operand MSB enters accumulator bit 0.
  - Decrement counter. On the edge where counter goes 1 -> 0: go to DONE, load D_bcd/R_bcd from the accumulators, out_valid = 1, busy = 0.
- Latency:
  - Non-error item: out_valid rises exactly Width edges after the capture edge E0.
  - Error item: out_valid rises 1 edge after E0.
- DONE:
  - out_valid = 1. D_bcd, R_bcd, err_out held stable until handshake.
  - At an edge with out_valid && out_ready: out_valid <= 0, state <= IDLE.
  - No IDLE bypass: minimum throughput is one item per Width+2 cycles (error items: 3 cycles).
- in_valid while not ready: ignored; the upstream holder must keep D/R/err stable until accepted.
- Arithmetic: add-3 operates per 4-bit digit with no inter-digit carry. Overflow is impossible given the DIGITS constraint; no checking logic is required.
- D = 0 or R = 0 with err = 0: full Width-cycle SHIFT still runs; result is all-zero BCD.
- out_ready high while not out_valid: ignored.

Test Plan:
- Width=4, DIGITS=2; D=15, R=3, err=0, out_ready=1 → out_valid 4 cycles after acceptance, D_bcd=8'h15, R_bcd=8'h03, err_out=0; in_ready low from acceptance until the cycle after output handshake.
- err=1, D=0, R=0 → out_valid 1 cycle after acceptance, D_bcd=8'h00, R_bcd=8'h00, err_out=1.
- Backpressure: D=9, R=7, out_ready held 0 for 6 cycles after out_valid → D_bcd=8'h09, R_bcd=8'h07 stable throughout, in_ready=0; handshake on the first out_ready=1 edge, then in_ready=1.
- Width=8, DIGITS=3; D=255, R=99 → D_bcd=12'h255, R_bcd=12'h099 after 8 cycles; D=100, R=0 → 12'h100, 12'h000.
- Reset mid-SHIFT: assert rst 2 cycles after accepting D=12 → next cycle out_valid=0, D_bcd=0, busy=0, in_ready=1 once rst drops; the aborted item never appears.
- Back-to-back: in_valid held high with values 1..5, out_ready=1 (Width=4) → results 01..05 in order, one every 6 cycles, none dropped or duplicated.
